// File: rtl/miriscv_branch_resolve.sv
// Execute-side branch resolution for a BTFN static predictor: in-order queue of
// fetch predictions, mispredict detection, registered redirect and perf counters.
module miriscv_branch_resolve #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = 32
) (
    input  logic              clk_i,
    input  logic              arstn_i,
    input  logic              push_valid_i,
    output logic              push_ready_o,
    input  logic [XLEN-1:0]   push_pc_i,
    input  logic              push_taken_i,
    input  logic [XLEN-1:0]   push_target_i,
    input  logic              res_valid_i,
    input  logic              res_taken_i,
    input  logic [XLEN-1:0]   res_target_i,
    input  logic              kill_i,
    output logic              redirect_o,
    output logic [XLEN-1:0]   redirect_pc_o,
    output logic              empty_o,
    output logic [CNT_W-1:0]  branch_cnt_o,
    output logic [CNT_W-1:0]  mispred_cnt_o,
    output logic              err_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [XLEN-1:0]  r_pc_mem  [DEPTH];
    logic [XLEN-1:0]  r_tgt_mem [DEPTH];
    logic [DEPTH-1:0] r_taken_mem;

    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W:0]   r_count;
    logic             r_redirect;
    logic [XLEN-1:0]  r_redirect_pc;
    logic [CNT_W-1:0] r_branch_cnt;
    logic [CNT_W-1:0] r_mispred_cnt;
    logic             r_err;

    logic             w_empty;
    logic             w_full;
    logic             w_push;
    logic             w_res;
    logic             w_mispred;
    logic             w_do_push;
    logic             w_do_pop;
    logic [XLEN-1:0]  w_head_pc;
    logic [XLEN-1:0]  w_head_tgt;
    logic             w_head_taken;
    logic [XLEN-1:0]  w_correct_pc;

    assign w_empty      = (r_count == '0);
    assign w_full       = (r_count == FULL_CNT);
    assign w_push       = push_valid_i & ~w_full;
    assign w_res        = res_valid_i & ~w_empty & ~kill_i;

    assign w_head_pc    = r_pc_mem[r_rd_ptr];
    assign w_head_tgt   = r_tgt_mem[r_rd_ptr];
    assign w_head_taken = r_taken_mem[r_rd_ptr];

    // A taken/taken pair still mispredicts when the computed target differs.
    assign w_mispred    = (res_taken_i != w_head_taken) |
                          (res_taken_i & w_head_taken & (res_target_i != w_head_tgt));
    assign w_correct_pc = res_taken_i ? res_target_i : (w_head_pc + XLEN'(4));

    // Wrong-path flushes swallow a same-cycle push even though its handshake completes.
    assign w_do_push    = w_push & ~kill_i & ~(w_res & w_mispred);
    assign w_do_pop     = w_res & ~w_mispred;

    // NOTE: the entry storage carries no reset; validity is tracked solely by
    // r_count, so resetting the array would only add reset fan-out.
    always_ff @(posedge clk_i) begin
        if (w_do_push) begin
            r_pc_mem[r_wr_ptr]    <= push_pc_i;
            r_tgt_mem[r_wr_ptr]   <= push_target_i;
            r_taken_mem[r_wr_ptr] <= push_taken_i;
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
            r_redirect    <= 1'b0;
            r_redirect_pc <= '0;
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
            r_err         <= 1'b0;
        end else begin
            r_redirect <= 1'b0;
            if (res_valid_i & w_empty & ~kill_i) begin
                r_err <= 1'b1;
            end
            if (w_res) begin
                if (r_branch_cnt != '1) begin
                    r_branch_cnt <= r_branch_cnt + 1'b1;
                end
            end
            if (kill_i || (w_res && w_mispred)) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_count  <= '0;
                if (!kill_i) begin
                    r_redirect    <= 1'b1;
                    r_redirect_pc <= w_correct_pc;
                    if (r_mispred_cnt != '1) begin
                        r_mispred_cnt <= r_mispred_cnt + 1'b1;
                    end
                end
            end else begin
                if (w_do_push) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_do_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                case ({w_do_push, w_do_pop})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    assign push_ready_o  = ~w_full;
    assign empty_o       = w_empty;
    assign redirect_o    = r_redirect;
    assign redirect_pc_o = r_redirect_pc;
    assign branch_cnt_o  = r_branch_cnt;
    assign mispred_cnt_o = r_mispred_cnt;
    assign err_o         = r_err;

endmodule
